// File: rtl/mdr_word_seq.sv
// Sequences one 16-bit word access as two byte transfers on the 8-bit RAM/MDR path.
// Latency: read 2*(WAIT_CYCLES+1) RD cycles then DONE, write 2 WR cycles then DONE; req is ignored while busy.
module mdr_word_seq #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              byte_high_we,
  output logic              byte_low_we
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_HI = 3'd1,
    RD_LO = 3'd2,
    WR_HI = 3'd3,
    WR_LO = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [3:0]        wait_q, wait_d;
  logic              lo_sel_q, lo_sel_d;
  logic              wait_last;

  assign wait_last = (wait_q == WAIT_LAST);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    lo_sel_d = lo_sel_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d   = addr;
          wdata_d  = wdata;
          wait_d   = 4'd0;
          lo_sel_d = 1'b0;
          state_d  = we ? WR_HI : RD_HI;
        end
      end
      RD_HI: begin
        if (wait_last) begin
          wait_d   = 4'd0;
          lo_sel_d = 1'b1;
          state_d  = RD_LO;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      RD_LO: begin
        if (wait_last) begin
          wait_d  = 4'd0;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      WR_HI: begin
        lo_sel_d = 1'b1;
        state_d  = WR_LO;
      end
      WR_LO:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_q   <= '0;
      lo_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      lo_sel_q <= lo_sel_d;
    end
  end

  // lo_sel_q stays set after the low byte so IDLE keeps presenting the last driven address
  assign mem_addr     = lo_sel_q ? addr_q + ADDR_W'(1) : addr_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign mem_re       = (state_q == RD_HI) || (state_q == RD_LO);
  assign mem_we       = (state_q == WR_HI) || (state_q == WR_LO);
  assign byte_high_we = (state_q == RD_HI) && wait_last;
  assign byte_low_we  = (state_q == RD_LO) && wait_last;

  always_comb begin
    mem_wdata = 8'h00;
    if (state_q == WR_HI) mem_wdata = wdata_q[15:8];
    else if (state_q == WR_LO) mem_wdata = wdata_q[7:0];
  end

endmodule

// File: tb/tb_mdr_word_seq.sv
// Bench for mdr_word_seq: three instances (WAIT_CYCLES 1, 0, 3) share a RAM/shift-register model;
// a per-cycle expected-output queue and a per-access result queue are checked as the DUT runs.
module tb_mdr_word_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;

  logic        req_i   [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic        re_o    [3];
  logic        mwe_o   [3];
  logic        hi_o    [3];
  logic        lo_o    [3];
  logic [15:0] maddr_o [3];
  logic [7:0]  mwd_o   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mdr_word_seq #(
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3)),
      .ADDR_W     (16)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req_i[g]),
      .we          (we),
      .addr        (addr),
      .wdata       (wdata),
      .busy        (busy_o[g]),
      .done        (done_o[g]),
      .mem_addr    (maddr_o[g]),
      .mem_re      (re_o[g]),
      .mem_we      (mwe_o[g]),
      .mem_wdata   (mwd_o[g]),
      .byte_high_we(hi_o[g]),
      .byte_low_we (lo_o[g])
    );
  end

  typedef struct packed {
    logic [29:0] v;
    logic [29:0] m;
  } rec_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] a;
    logic [15:0] w;
  } res_t;

  localparam logic [29:0] M_ALL    = 30'h3FFF_FFFF;
  localparam logic [29:0] M_NOADDR = 30'h3F00_00FF;

  rec_t        exp_q[$];
  res_t        res_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          sel = 0;
  logic        mon_en = 1'b0;
  logic [15:0] last_addr [3];
  logic [7:0]  wr_mem [int];
  logic [15:0] sr = 16'h0000;
  logic [29:0] obs;
  rec_t        cur;
  res_t        cur_res;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", tag, got, want, $time, sel);
    end
  endtask

  function automatic int wc(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  function automatic logic [7:0] ram_rd(input logic [15:0] a);
    if (wr_mem.exists(int'(a))) return wr_mem[int'(a)];
    if (a == 16'h1200) return 8'hAB;
    if (a == 16'h1201) return 8'hCD;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [29:0] pk(input logic b, input logic d, input logic r, input logic w,
                                     input logic h, input logic l, input logic [15:0] a,
                                     input logic [7:0] wd);
    return {b, d, r, w, h, l, a, wd};
  endfunction

  task automatic push_rec(input logic [29:0] v, input logic [29:0] m);
    rec_t r;
    r.v = v;
    r.m = m;
    exp_q.push_back(r);
  endtask

  // Expected cycle-by-cycle outputs of one access on instance sel, starting the cycle after accept
  task automatic push_access(input logic w, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] a1;
    res_t        rs;
    a1 = a + 16'd1;
    if (!w) begin
      for (int i = 0; i <= wc(sel); i++) push_rec(pk(1, 0, 1, 0, i == wc(sel), 0, a, 8'h00), M_ALL);
      for (int i = 0; i <= wc(sel); i++) push_rec(pk(1, 0, 1, 0, 0, i == wc(sel), a1, 8'h00), M_ALL);
      rs.w = {ram_rd(a), ram_rd(a1)};
    end else begin
      push_rec(pk(1, 0, 0, 1, 0, 0, a, d[15:8]), M_ALL);
      push_rec(pk(1, 0, 0, 1, 0, 0, a1, d[7:0]), M_ALL);
      rs.w = d;
    end
    push_rec(pk(1, 1, 0, 0, 0, 0, 16'h0000, 8'h00), M_NOADDR);
    rs.wr = w;
    rs.a  = a;
    res_q.push_back(rs);
    last_addr[sel] = a1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_access(input int g, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    sel      = g;
    we       = w;
    addr     = a;
    wdata    = d;
    req_i[g] = 1'b1;
    @(posedge clk);
    #1;
    push_access(w, a, d);
    req_i[g] = 1'b0;
    addr     = 16'($urandom);
    wdata    = 16'($urandom);
    we       = 1'($urandom);
    wait_drain();
  endtask

  always @(posedge clk) begin
    if (mwe_o[sel]) wr_mem[int'(maddr_o[sel])] = mwd_o[sel];
    if (hi_o[sel]) sr[15:8] <= ram_rd(maddr_o[sel]);
    if (lo_o[sel]) sr[7:0] <= ram_rd(maddr_o[sel]);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      obs = pk(busy_o[sel], done_o[sel], re_o[sel], mwe_o[sel], hi_o[sel], lo_o[sel],
               maddr_o[sel], mwd_o[sel]);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("trace", obs & cur.m, cur.v & cur.m);
      end else begin
        chk("idle", obs, pk(0, 0, 0, 0, 0, 0, last_addr[sel], 8'h00));
      end
      if (done_o[sel]) begin
        if (res_q.size() == 0) begin
          chk("spurious_done", done_o[sel], 0);
        end else begin
          cur_res = res_q.pop_front();
          if (cur_res.wr) chk("ram_word", {ram_rd(cur_res.a), ram_rd(cur_res.a + 16'd1)}, cur_res.w);
          else chk("sr_word", sr, cur_res.w);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    addr  = 16'h0000;
    wdata = 16'h0000;
    for (int g = 0; g < 3; g++) begin
      req_i[g]     = 1'b0;
      last_addr[g] = 16'h0000;
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int g = 0; g < 3; g++)
      chk("reset_state", pk(busy_o[g], done_o[g], re_o[g], mwe_o[g], hi_o[g], lo_o[g],
                            maddr_o[g], mwd_o[g]), 30'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    do_access(0, 1'b0, 16'h1200, 16'h0000);
    do_access(0, 1'b1, 16'h0040, 16'hBEEF);
    do_access(1, 1'b0, 16'hFFFF, 16'h0000);

    // req held through a read while addr changes; second access starts after one IDLE cycle
    @(posedge clk);
    #1;
    sel      = 0;
    we       = 1'b0;
    addr     = 16'h0010;
    req_i[0] = 1'b1;
    @(posedge clk);
    #1;
    push_access(1'b0, 16'h0010, 16'h0000);
    push_rec(pk(0, 0, 0, 0, 0, 0, 16'h0011, 8'h00), M_ALL);
    push_access(1'b0, 16'h0020, 16'h0000);
    @(posedge clk);
    #1;
    addr = 16'h0020;
    repeat (6) @(posedge clk);
    #1;
    req_i[0] = 1'b0;
    wait_drain();

    // reset during the first RD_LO cycle aborts the read
    @(posedge clk);
    #1;
    sel      = 0;
    we       = 1'b0;
    addr     = 16'h0100;
    req_i[0] = 1'b1;
    @(posedge clk);
    #1;
    push_access(1'b0, 16'h0100, 16'h0000);
    req_i[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    res_q.delete();
    for (int g = 0; g < 3; g++) last_addr[g] = 16'h0000;
    repeat (2) @(posedge clk);
    do_access(0, 1'b0, 16'h0002, 16'h0000);

    do_access(2, 1'b0, 16'h3000, 16'h0000);
    do_access(2, 1'b0, 16'h0040, 16'h0000);
    do_access(2, 1'b1, 16'h7FFF, 16'h1234);

    for (int k = 0; k < 8; k++)
      do_access(int'($urandom_range(2, 0)), 1'($urandom), 16'($urandom), 16'($urandom));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
